// File: rtl/lanzones_pkg.sv
// Shared types and constants for the lanzones memory-side blocks.
package lanzones_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
endpackage

// File: rtl/rr_arb2.sv
// Two-input picker: round-robin (mode=1) or fixed priority with port 1 winning (mode=0).
module rr_arb2
  import lanzones_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       mode_i,
  output logic       gnt_idx_o
);
  always_comb begin
    gnt_idx_o = PORT_FETCH;
    // A tie goes to whichever port did not win last; a lone request always wins.
    if (mode_i && (&req_i)) gnt_idx_o = ~last_i;
    else if (req_i[1])      gnt_idx_o = PORT_LOAD;
  end
endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one memory read port between fetch (port 0) and load (port 1),
// one outstanding read at a time, with a response timeout.
module mem_rd_arbiter
  import lanzones_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int RR      = 1,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Req0,
  input  logic [AW-1:0] Addr0,
  output logic          Gnt0,
  output logic          Vld0,
  output logic [DW-1:0] Data0,
  input  logic          Req1,
  input  logic [AW-1:0] Addr1,
  output logic          Gnt1,
  output logic          Vld1,
  output logic [DW-1:0] Data1,
  output logic          RRdy,
  output logic [AW-1:0] RAddr,
  input  logic          RVld,
  input  logic [DW-1:0] RData,
  output logic          Err
);
  localparam int              TW      = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]   TMAX    = TW'(TIMEOUT - 1);
  localparam logic            RR_MODE = (RR != 0);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_last_q, rr_last_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pick;

  rr_arb2 u_arb (
    .req_i     ({Req1, Req0}),
    .last_i    (rr_last_q),
    .mode_i    (RR_MODE),
    .gnt_idx_o (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= PORT_FETCH;
      rr_last_q <= 1'b1;
      raddr_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      raddr_q   <= raddr_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    raddr_d   = raddr_q;
    timer_d   = timer_q;
    Gnt0      = 1'b0;
    Gnt1      = 1'b0;
    Vld0      = 1'b0;
    Vld1      = 1'b0;
    RRdy      = 1'b0;
    Err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // RVld here belongs to no transaction and is dropped.
        if (Req0 || Req1) begin
          owner_d = pick;
          raddr_d = pick ? Addr1 : Addr0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        RRdy    = 1'b1;
        Gnt0    = (owner_q == PORT_FETCH);
        Gnt1    = (owner_q == PORT_LOAD);
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A response on the last allowed cycle still beats the abort.
        if (RVld) begin
          Vld0    = (owner_q == PORT_FETCH);
          Vld1    = (owner_q == PORT_LOAD);
          if (RR_MODE) rr_last_d = owner_q;
          state_d = IDLE;
        end else if (timer_q == TMAX) begin
          Err     = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RAddr = raddr_q;
  assign Data0 = RData;
  assign Data1 = RData;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Random + directed bench for mem_rd_arbiter: one round-robin and one fixed-priority instance.
module tb_mem_rd_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, rvld = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, rdata = '0;

  logic        gnt0_r, gnt1_r, vld0_r, vld1_r, rrdy_r, err_r;
  logic [31:0] raddr_r, data0_r, data1_r;
  logic        gnt0_f, gnt1_f, vld0_f, vld1_f, rrdy_f, err_f;
  logic [31:0] raddr_f, data0_f, data1_f;
  logic        gnt0, gnt1, vld0, vld1, rrdy, err;
  logic [31:0] raddr, data0, data1;

  int n_chk = 0, n_ok = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_rd_arbiter #(.AW(32), .DW(32), .RR(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst),
    .Req0(req0 & ~sel), .Addr0(addr0), .Gnt0(gnt0_r), .Vld0(vld0_r), .Data0(data0_r),
    .Req1(req1 & ~sel), .Addr1(addr1), .Gnt1(gnt1_r), .Vld1(vld1_r), .Data1(data1_r),
    .RRdy(rrdy_r), .RAddr(raddr_r), .RVld(rvld), .RData(rdata), .Err(err_r)
  );

  mem_rd_arbiter #(.AW(32), .DW(32), .RR(0), .TIMEOUT(TO)) u_fp (
    .clk(clk), .rst(rst),
    .Req0(req0 & sel), .Addr0(addr0), .Gnt0(gnt0_f), .Vld0(vld0_f), .Data0(data0_f),
    .Req1(req1 & sel), .Addr1(addr1), .Gnt1(gnt1_f), .Vld1(vld1_f), .Data1(data1_f),
    .RRdy(rrdy_f), .RAddr(raddr_f), .RVld(rvld), .RData(rdata), .Err(err_f)
  );

  assign gnt0  = sel ? gnt0_f  : gnt0_r;
  assign gnt1  = sel ? gnt1_f  : gnt1_r;
  assign vld0  = sel ? vld0_f  : vld0_r;
  assign vld1  = sel ? vld1_f  : vld1_r;
  assign rrdy  = sel ? rrdy_f  : rrdy_r;
  assign err   = sel ? err_f   : err_r;
  assign raddr = sel ? raddr_f : raddr_r;
  assign data0 = sel ? data0_f : data0_r;
  assign data1 = sel ? data1_f : data1_r;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rvld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"},  {gnt1, gnt0}, 2'b00);
    chk({tag, "_vld"},  {vld1, vld0}, 2'b00);
    chk({tag, "_rrdy"}, rrdy, 1'b0);
    chk({tag, "_err"},  err, 1'b0);
  endtask

  // Transaction-timeline model: each grant is scheduled from the cycle the
  // arbiter is idle with a request present, and the bench picks the memory delay.
  task automatic run_random(input int n, input bit rr);
    bit          act, ok, last;
    int          own, t_iss, t_end, d;
    bit          pend [2];
    logic [31:0] paddr [2];
    logic [31:0] oaddr;
    act = 0; ok = 0; last = 1; own = 0; t_iss = 0; t_end = 0; d = 0; oaddr = '0;
    pend[0] = 0; pend[1] = 0; paddr[0] = '0; paddr[1] = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (act && c == t_iss + 1) pend[own] = 0;
      if (act && c > t_end) act = 0;
      for (int p = 0; p < 2; p++)
        if (!pend[p] && !(act && own == p && c < t_end) && ($urandom % 3 == 0)) begin
          pend[p]  = 1;
          paddr[p] = $urandom & ~32'h3;
        end
      req0 = pend[0]; req1 = pend[1]; addr0 = paddr[0]; addr1 = paddr[1];
      rvld = 1'b0; rdata = $urandom;
      if (!act) begin
        if ($urandom % 5 == 0) rvld = 1'b1;
        if (pend[0] || pend[1]) begin
          if (rr && pend[0] && pend[1]) own = last ? 0 : 1;
          else                          own = pend[1] ? 1 : 0;
          oaddr = paddr[own]; act = 1; t_iss = c + 1;
          case ($urandom % 10)
            0:       d = TO - 1;
            1:       d = TO;
            default: d = $urandom % 4;
          endcase
          ok    = (d < TO);
          t_end = c + 2 + (ok ? d : TO - 1);
        end
      end else if (c == t_end && ok) begin
        rvld = 1'b1; rdata = memw(oaddr);
      end
      @(negedge clk);
      chk("gnt", {gnt1, gnt0}, (act && c == t_iss) ? (own == 1 ? 2'b10 : 2'b01) : 2'b00);
      chk("rrdy", rrdy, act && c == t_iss);
      if (act && c == t_iss) chk("raddr", raddr, oaddr);
      chk("vld", {vld1, vld0}, (act && c == t_end && ok) ? (own == 1 ? 2'b10 : 2'b01) : 2'b00);
      chk("err", err, act && c == t_end && !ok);
      chk("data", {data1, data0}, {rdata, rdata});
      if (act && c == t_end && ok) begin
        chk("vdata", own == 1 ? data1 : data0, memw(oaddr));
        if (rr) last = (own == 1);
      end
    end
  endtask

  initial begin
    do_reset();
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_raddr", raddr, 32'h0);

    // single fetch
    @(posedge clk); #1 req0 = 1'b1; addr0 = 32'h10;
    @(negedge clk); chk_quiet("sf_idle");
    @(posedge clk); #1;
    @(negedge clk);
    chk("sf_gnt", {gnt1, gnt0}, 2'b01);
    chk("sf_rrdy", rrdy, 1'b1);
    chk("sf_raddr", raddr, 32'h10);
    @(posedge clk); #1 req0 = 1'b0; rvld = 1'b1; rdata = 32'h1234;
    @(negedge clk);
    chk("sf_vld", {vld1, vld0}, 2'b01);
    chk("sf_data", data0, 32'h1234);
    @(posedge clk); #1 rvld = 1'b0;

    // first tie after reset goes to port 0, then port 1, then reset mid-WAIT
    do_reset();
    @(posedge clk); #1 req0 = 1'b1; addr0 = 32'h40; req1 = 1'b1; addr1 = 32'h80;
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie_gnt", {gnt1, gnt0}, 2'b01);
    chk("tie_raddr", raddr, 32'h40);
    @(posedge clk); #1 req0 = 1'b0; rvld = 1'b1; rdata = memw(32'h40);
    @(negedge clk); chk("tie_vld", {vld1, vld0}, 2'b01);
    @(posedge clk); #1 rvld = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie2_gnt", {gnt1, gnt0}, 2'b10);
    chk("tie2_raddr", raddr, 32'h80);
    @(posedge clk); #1 req1 = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("mid_rst");
    chk("mid_rst_raddr", raddr, 32'h0);
    @(posedge clk); #1 rvld = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk); chk_quiet("late_rvld");
    @(posedge clk); #1 rvld = 1'b0;

    do_reset();
    run_random(1500, 1'b1);
    do_reset();
    sel = 1'b1;
    run_random(1500, 1'b0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
